alu_sequencer: RTL and testbench

//  Control-side counterpart of the 8-bit datapath ALU. Accepts one 6502 arithmetic/logic op per request over

---
 rtl/alu_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues one 6502 ALU op per request to the 8-bit datapath ALU,
// runs a second correction pass for decimal ADC/SBC, returns result + NVZC.
// Ports: i_clk, i_rst_n (async, active low); req valid/ready + op/a/b/c/d;
// o_alu_* drive the ALU, i_alu_* come back; rsp valid/ready + result/wr/flags/flag_we/err.
module alu_sequencer (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_req_valid,
   output logic       o_req_ready,
   input  logic [3:0] i_req_op,
   input  logic [7:0] i_req_a,
   input  logic [7:0] i_req_b,
   input  logic       i_req_c,
   input  logic       i_req_d,
   output logic [7:0] o_alu_op_a,
   output logic [7:0] o_alu_op_b,
   output logic       o_alu_cin,
   output logic [1:0] o_alu_op_sel,
   output logic [1:0] o_alu_bool_op,
   output logic       o_alu_sub,
   output logic       o_alu_dec,
   input  logic [7:0] i_alu_result,
   input  logic       i_alu_cout,
   output logic       o_rsp_valid,
   input  logic       i_rsp_ready,
   output logic [7:0] o_rsp_result,
   output logic       o_rsp_wr,
   output logic [3:0] o_rsp_flags,
   output logic [3:0] o_rsp_flag_we,
   output logic       o_rsp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, FIX, RESP} state_t;

   state_t     state_q, state_d;
   logic [3:0] op_q;
   logic [7:0] a_q, b_q;
   logic       c_q, d_q;
   logic [7:0] bin_q;
   logic       cout_q, hc_q;

   logic is_adc, is_sbc, is_and, is_ora, is_eor, is_lsr;
   logic is_asl, is_rol, is_ror, is_cmp, is_inc, is_dec;
   logic arith, decimal, load_rsp;

   assign is_adc  = (op_q == 4'h0);
   assign is_sbc  = (op_q == 4'h1);
   assign is_and  = (op_q == 4'h2);
   assign is_ora  = (op_q == 4'h3);
   assign is_eor  = (op_q == 4'h4);
   assign is_lsr  = (op_q == 4'h5);
   assign is_asl  = (op_q == 4'h6);
   assign is_rol  = (op_q == 4'h7);
   assign is_ror  = (op_q == 4'h8);
   assign is_cmp  = (op_q == 4'h9);
   assign is_inc  = (op_q == 4'ha);
   assign is_dec  = (op_q == 4'hb);
   assign arith   = is_adc | is_sbc;
   assign decimal = arith & d_q;

   // Effective B as the adder sees it (SBC is A + ~B + C)
   logic [7:0] bp;
   logic [4:0] nib;
   assign bp  = is_sbc ? ~b_q : b_q;
   assign nib = {1'b0, a_q[3:0]} + {1'b0, bp[3:0]} + {4'b0, c_q};

   // Decimal correction from the captured binary pass
   logic [7:0] corr_lo, corr_hi, corr;
   always_comb begin
      corr_lo = 8'h00;
      corr_hi = 8'h00;
      if (is_sbc) begin
         if (!hc_q)   corr_lo = 8'hfa;
         if (!cout_q) corr_hi = 8'ha0;
      end else begin
         if (hc_q || (bin_q[3:0] > 4'd9))  corr_lo = 8'h06;
         if (cout_q || (bin_q > 8'h99))    corr_hi = 8'h60;
      end
      corr = corr_lo + corr_hi;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (i_req_valid) state_d = EXEC;
         EXEC: state_d = decimal ? FIX : RESP;
         FIX:  state_d = RESP;
         RESP: if (i_rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign o_req_ready = (state_q == IDLE);

   // ALU drive, combinational from the latched request
   always_comb begin
      o_alu_op_a    = 8'h00;
      o_alu_op_b    = 8'h00;
      o_alu_cin     = 1'b0;
      o_alu_op_sel  = 2'd0;
      o_alu_bool_op = 2'd0;
      o_alu_sub     = 1'b0;
      o_alu_dec     = 1'b0;
      if (state_q == FIX) begin
         o_alu_op_a = bin_q;
         o_alu_op_b = corr;
         o_alu_dec  = d_q;
      end else if (state_q == EXEC) begin
         unique case (1'b1)
            is_adc: begin
               o_alu_op_a = a_q;
               o_alu_op_b = b_q;
               o_alu_cin  = c_q;
               o_alu_dec  = d_q;
            end
            is_sbc: begin
               o_alu_op_a = a_q;
               o_alu_op_b = b_q;
               o_alu_cin  = c_q;
               o_alu_sub  = 1'b1;
               o_alu_dec  = d_q;
            end
            is_and, is_ora, is_eor: begin
               o_alu_op_sel  = 2'd1;
               o_alu_op_a    = a_q;
               o_alu_op_b    = b_q;
               o_alu_bool_op = is_and ? 2'd3 : (is_ora ? 2'd2 : 2'd0);
            end
            is_lsr, is_ror: begin
               o_alu_op_sel = 2'd2;
               o_alu_op_a   = a_q;
            end
            is_asl, is_rol: begin
               o_alu_op_a = a_q;
               o_alu_op_b = a_q;
               o_alu_cin  = is_rol & c_q;
            end
            is_cmp: begin
               o_alu_op_a = a_q;
               o_alu_op_b = b_q;
               o_alu_cin  = 1'b1;
               o_alu_sub  = 1'b1;
            end
            is_inc: begin
               o_alu_op_a = a_q;
               o_alu_cin  = 1'b1;
            end
            is_dec: begin
               o_alu_op_a = a_q;
               o_alu_sub  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Response computed from the ALU output of the final pass
   logic [7:0] bin_r, res_n;
   logic [3:0] we_n;
   logic       c_n, v_n, wr_n, err_n;

   assign bin_r = (state_q == FIX) ? bin_q : i_alu_result;
   assign v_n   = arith & (a_q[7] == bp[7]) & (bin_r[7] != a_q[7]);

   always_comb begin
      res_n = i_alu_result;
      c_n   = 1'b0;
      we_n  = 4'b1010;
      wr_n  = 1'b1;
      err_n = 1'b0;
      unique case (1'b1)
         is_adc, is_sbc: begin
            we_n = 4'b1111;
            c_n  = i_alu_cout;
            if (state_q == FIX)
               c_n = is_adc ? (i_alu_cout | (|corr[6:5])) : cout_q;
         end
         is_and, is_ora, is_eor, is_inc, is_dec: ;
         is_lsr: begin
            we_n = 4'b1011;
            c_n  = a_q[0];
         end
         is_ror: begin
            we_n  = 4'b1011;
            res_n = i_alu_result | {c_q, 7'b0};
            c_n   = a_q[0];
         end
         is_asl, is_rol: begin
            we_n = 4'b1011;
            c_n  = i_alu_cout;
         end
         is_cmp: begin
            we_n = 4'b1011;
            c_n  = i_alu_cout;
            wr_n = 1'b0;
         end
         default: begin
            res_n = a_q;
            we_n  = 4'b0000;
            wr_n  = 1'b0;
            err_n = 1'b1;
         end
      endcase
   end

   assign load_rsp = ((state_q == EXEC) && !decimal) || (state_q == FIX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_q          <= 4'h0;
         a_q           <= 8'h00;
         b_q           <= 8'h00;
         c_q           <= 1'b0;
         d_q           <= 1'b0;
         bin_q         <= 8'h00;
         cout_q        <= 1'b0;
         hc_q          <= 1'b0;
         o_rsp_valid   <= 1'b0;
         o_rsp_result  <= 8'h00;
         o_rsp_wr      <= 1'b0;
         o_rsp_flags   <= 4'h0;
         o_rsp_flag_we <= 4'h0;
         o_rsp_err     <= 1'b0;
      end else begin
         if ((state_q == IDLE) && i_req_valid) begin
            op_q <= i_req_op;
            a_q  <= i_req_a;
            b_q  <= i_req_b;
            c_q  <= i_req_c;
            d_q  <= i_req_d;
         end
         if (state_q == EXEC) begin
            bin_q  <= i_alu_result;
            cout_q <= i_alu_cout;
            hc_q   <= nib[4];
         end
         if (load_rsp) begin
            o_rsp_valid   <= 1'b1;
            o_rsp_result  <= res_n;
            o_rsp_wr      <= wr_n;
            o_rsp_flags   <= err_n ? 4'h0 :
                             {res_n[7], v_n, res_n == 8'h00, c_n};
            o_rsp_flag_we <= we_n;
            o_rsp_err     <= err_n;
         end else if ((state_q == RESP) && i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: random + directed bench for alu_sequencer with an
// ALU model on the o_alu_* side and a flag-level reference model.
module tb_alu_sequencer;

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_req_valid = 1'b0;
   logic       o_req_ready;
   logic [3:0] i_req_op = 4'h0;
   logic [7:0] i_req_a = 8'h00;
   logic [7:0] i_req_b = 8'h00;
   logic       i_req_c = 1'b0;
   logic       i_req_d = 1'b0;
   logic [7:0] o_alu_op_a, o_alu_op_b;
   logic       o_alu_cin, o_alu_sub, o_alu_dec;
   logic [1:0] o_alu_op_sel, o_alu_bool_op;
   logic [7:0] alu_result;
   logic       alu_cout;
   logic       o_rsp_valid;
   logic       i_rsp_ready = 1'b1;
   logic [7:0] o_rsp_result;
   logic       o_rsp_wr, o_rsp_err;
   logic [3:0] o_rsp_flags, o_rsp_flag_we;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   alu_sequencer dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_op(i_req_op), .i_req_a(i_req_a), .i_req_b(i_req_b),
      .i_req_c(i_req_c), .i_req_d(i_req_d),
      .o_alu_op_a(o_alu_op_a), .o_alu_op_b(o_alu_op_b),
      .o_alu_cin(o_alu_cin), .o_alu_op_sel(o_alu_op_sel),
      .o_alu_bool_op(o_alu_bool_op), .o_alu_sub(o_alu_sub),
      .o_alu_dec(o_alu_dec),
      .i_alu_result(alu_result), .i_alu_cout(alu_cout),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_result(o_rsp_result), .o_rsp_wr(o_rsp_wr),
      .o_rsp_flags(o_rsp_flags), .o_rsp_flag_we(o_rsp_flag_we),
      .o_rsp_err(o_rsp_err)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Binary datapath ALU; decimal correction is the sequencer's job
   logic [7:0] alu_bb;
   logic [8:0] alu_s;
   always_comb begin
      alu_bb     = o_alu_sub ? ~o_alu_op_b : o_alu_op_b;
      alu_s      = {1'b0, o_alu_op_a} + {1'b0, alu_bb} + {8'b0, o_alu_cin};
      alu_result = alu_s[7:0];
      alu_cout   = alu_s[8];
      if (o_alu_op_sel == 2'd1) begin
         alu_cout = 1'b0;
         case (o_alu_bool_op)
            2'd0:    alu_result = o_alu_op_a ^ o_alu_op_b;
            2'd2:    alu_result = o_alu_op_a | o_alu_op_b;
            default: alu_result = o_alu_op_a & o_alu_op_b;
         endcase
      end else if (o_alu_op_sel == 2'd2) begin
         alu_result = o_alu_op_a >> 1;
         alu_cout   = o_alu_op_a[0];
      end
   end

   typedef struct {
      logic [7:0] r;
      logic [3:0] f;
      logic [3:0] we;
      logic       wr;
      logic       err;
      int         lat;
   } exp_t;

   function automatic exp_t model(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic c,
                                  input logic d);
      exp_t e;
      logic [7:0] bp, bin, corr, r;
      logic [9:0] s, fs;
      logic [4:0] h;
      logic co, v, cf;
      e.wr = 1'b1; e.err = 1'b0; e.lat = 1; e.we = 4'b1010;
      v = 1'b0; cf = 1'b0; r = 8'h00;
      case (op)
         4'h0, 4'h1: begin
            bp  = (op == 4'h1) ? ~b : b;
            s   = {2'b0, a} + {2'b0, bp} + {9'b0, c};
            bin = s[7:0];
            co  = s[8];
            v   = (a[7] == bp[7]) && (bin[7] != a[7]);
            e.we = 4'b1111;
            r = bin; cf = co;
            if (d) begin
               e.lat = 2;
               h = {1'b0, a[3:0]} + {1'b0, bp[3:0]} + {4'b0, c};
               if (op == 4'h0) begin
                  corr = ((h > 5'd15) || (bin[3:0] > 4'd9)) ? 8'h06 : 8'h00;
                  if (co || bin > 8'h99) corr = corr + 8'h60;
                  fs = {2'b0, bin} + {2'b0, corr};
                  r  = fs[7:0];
                  cf = fs[8] || (corr >= 8'h60);
               end else begin
                  corr = (h > 5'd15) ? 8'h00 : 8'hfa;
                  if (!co) corr = corr + 8'ha0;
                  r = bin + corr;
               end
            end
         end
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'h4: r = a ^ b;
         4'h5: begin r = a >> 1; cf = a[0]; e.we = 4'b1011; end
         4'h6: begin r = a << 1; cf = a[7]; e.we = 4'b1011; end
         4'h7: begin r = {a[6:0], c}; cf = a[7]; e.we = 4'b1011; end
         4'h8: begin r = {c, a[7:1]}; cf = a[0]; e.we = 4'b1011; end
         4'h9: begin
            r = a - b; cf = (a >= b); e.we = 4'b1011; e.wr = 1'b0;
         end
         4'ha: r = a + 8'h01;
         4'hb: r = a - 8'h01;
         default: begin
            r = a; e.we = 4'b0000; e.wr = 1'b0; e.err = 1'b1;
         end
      endcase
      e.r = r;
      e.f = {r[7], v, r == 8'h00, cf};
      return e;
   endfunction

   // Drives one request; returns what the DUT responded with
   task automatic txn(input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic c, input logic d,
                      output int lat, output int acc,
                      output logic [7:0] res, output logic [3:0] fl,
                      output logic [3:0] we, output logic wr,
                      output logic err);
      i_req_op = op; i_req_a = a; i_req_b = b;
      i_req_c = c; i_req_d = d; i_req_valid = 1'b1;
      for (int k = 0; k < 20 && !o_req_ready; k++) begin
         @(posedge i_clk); #1;
      end
      @(posedge i_clk);
      acc = cyc;
      #1;
      i_req_valid = 1'b0;
      lat = -1;
      res = 8'h00; fl = 4'h0; we = 4'h0; wr = 1'b0; err = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge i_clk); #1;
         if (o_rsp_valid) begin
            lat = k; res = o_rsp_result; fl = o_rsp_flags;
            we = o_rsp_flag_we; wr = o_rsp_wr; err = o_rsp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({o_rsp_valid, o_rsp_result, o_rsp_wr, o_rsp_flags,
           o_rsp_flag_we, o_rsp_err} !== 19'h0) begin
         errors++;
         $display("FAIL reset_rsp: got valid=%b res=%h flags=%h we=%h, want 0",
                  o_rsp_valid, o_rsp_result, o_rsp_flags, o_rsp_flag_we);
      end
      checks++;
      if ({o_alu_op_a, o_alu_op_b, o_alu_cin, o_alu_op_sel,
           o_alu_bool_op, o_alu_sub, o_alu_dec} !== 24'h0) begin
         errors++;
         $display("FAIL reset_alu: got a=%h b=%h, want all 0",
                  o_alu_op_a, o_alu_op_b);
      end
      checks++;
      if (o_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", o_req_ready);
      end
   endtask

   logic [3:0] t_op [9] = '{4'h0, 4'h1, 4'h0, 4'h8, 4'h9, 4'ha, 4'hb, 4'h6, 4'h2};
   logic [7:0] t_a  [9] = '{8'h50, 8'h42, 8'h99, 8'h01, 8'h10, 8'hff, 8'h00, 8'h81, 8'hf0};
   logic [7:0] t_b  [9] = '{8'h50, 8'h13, 8'h01, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00, 8'h3c};
   logic       t_c  [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic       t_d  [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [7:0] t_r  [9] = '{8'ha0, 8'h29, 8'h00, 8'h80, 8'hf0, 8'h00, 8'hff, 8'h02, 8'h30};
   logic [3:0] t_f  [9] = '{4'hc, 4'h1, 4'h3, 4'h9, 4'h8, 4'h2, 4'h8, 4'h1, 4'h0};
   logic [3:0] t_we [9] = '{4'hf, 4'hf, 4'hf, 4'hb, 4'hb, 4'ha, 4'ha, 4'hb, 4'ha};
   logic       t_wr [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   int         t_lt [9] = '{1, 2, 2, 1, 1, 1, 1, 1, 1};

   task automatic test_directed();
      int lat, acc;
      logic [7:0] r;
      logic [3:0] f, we;
      logic wr, err;
      for (int i = 0; i < 9; i++) begin
         txn(t_op[i], t_a[i], t_b[i], t_c[i], t_d[i], lat, acc, r, f, we, wr, err);
         checks++;
         if (lat != t_lt[i] || r !== t_r[i] || (f & we) !== t_f[i] ||
             we !== t_we[i] || wr !== t_wr[i] || err !== 1'b0) begin
            errors++;
            $display("FAIL directed_%0d: got lat=%0d r=%h f=%h we=%h wr=%b err=%b want lat=%0d r=%h f=%h we=%h wr=%b err=0",
                     i, lat, r, f & we, we, wr, err, t_lt[i], t_r[i], t_f[i],
                     t_we[i], t_wr[i]);
         end
      end
   endtask

   task automatic test_random();
      int lat, acc;
      logic [7:0] r, a, b;
      logic [3:0] f, we, op;
      logic wr, err, c, d;
      exp_t e;
      for (int i = 0; i < 300; i++) begin
         op = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(12, 15))
                                           : 4'($urandom_range(0, 11));
         a = 8'($urandom); b = 8'($urandom);
         c = 1'($urandom); d = 1'($urandom);
         e = model(op, a, b, c, d);
         txn(op, a, b, c, d, lat, acc, r, f, we, wr, err);
         checks++;
         if (lat != e.lat || r !== e.r || (f & we) !== (e.f & e.we) ||
             we !== e.we || wr !== e.wr || err !== e.err) begin
            errors++;
            $display("FAIL random op=%h a=%h b=%h c=%b d=%b: got lat=%0d r=%h f=%h we=%h wr=%b err=%b want lat=%0d r=%h f=%h we=%h wr=%b err=%b",
                     op, a, b, c, d, lat, r, f & we, we, wr, err,
                     e.lat, e.r, e.f & e.we, e.we, e.wr, e.err);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat, acc, prev;
      logic [7:0] r;
      logic [3:0] f, we;
      logic wr, err, d;
      txn(4'h2, 8'h0f, 8'hff, 1'b0, 1'b0, lat, prev, r, f, we, wr, err);
      for (int i = 0; i < 8; i++) begin
         d = 1'(i % 2);
         txn(4'h0, 8'($urandom), 8'($urandom), 1'b0, d, lat, acc, r, f, we, wr, err);
         checks++;
         // accept-to-accept gap follows the previous op's pass count
         if (acc - prev != ((i % 2 == 1) ? 3 : (i == 0 ? 3 : 4))) begin
            errors++;
            $display("FAIL issue_interval_%0d: got %0d cycles", i, acc - prev);
         end
         prev = acc;
      end
   endtask

   task automatic test_illegal();
      int lat, acc;
      logic [7:0] r, a;
      logic [3:0] f, we;
      logic wr, err;
      a = 8'($urandom);
      txn(4'hd, a, 8'h5a, 1'b1, 1'b1, lat, acc, r, f, we, wr, err);
      checks++;
      if (lat != 1 || r !== a || we !== 4'h0 || wr !== 1'b0 || err !== 1'b1) begin
         errors++;
         $display("FAIL illegal: got lat=%0d r=%h we=%h wr=%b err=%b want 1 %h 0 0 1",
                  lat, r, we, wr, err, a);
      end
   endtask

   task automatic test_hold_and_reset();
      int lat, acc;
      logic [7:0] r;
      logic [3:0] f, we;
      logic wr, err;
      logic [18:0] snap;
      i_rsp_ready = 1'b0;
      txn(4'h0, 8'h50, 8'h50, 1'b0, 1'b0, lat, acc, r, f, we, wr, err);
      snap = {o_rsp_valid, o_rsp_result, o_rsp_wr, o_rsp_flags, o_rsp_flag_we, o_rsp_err};
      for (int k = 0; k < 5; k++) begin
         @(posedge i_clk); #1;
         checks++;
         if ({o_rsp_valid, o_rsp_result, o_rsp_wr, o_rsp_flags, o_rsp_flag_we,
              o_rsp_err} !== snap || snap[18] !== 1'b1 || o_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_%0d: got valid=%b res=%h ready=%b want 1 %h 0",
                     k, o_rsp_valid, o_rsp_result, o_req_ready, snap[17:10]);
         end
      end
      i_rsp_ready = 1'b1;
      i_req_op = 4'h1; i_req_a = 8'h42; i_req_b = 8'h13;
      i_req_c = 1'b1; i_req_d = 1'b1; i_req_valid = 1'b1;
      for (int k = 0; k < 10 && !o_req_ready; k++) begin
         @(posedge i_clk); #1;
      end
      @(posedge i_clk); #1;
      i_req_valid = 1'b0;
      checks++;
      if (o_alu_op_a !== 8'h42 || o_alu_op_b !== 8'h13 || o_alu_sub !== 1'b1 ||
          o_alu_dec !== 1'b1 || o_alu_cin !== 1'b1 || o_alu_op_sel !== 2'd0) begin
         errors++;
         $display("FAIL exec_drive: got a=%h b=%h sub=%b dec=%b cin=%b sel=%0d want 42 13 1 1 1 0",
                  o_alu_op_a, o_alu_op_b, o_alu_sub, o_alu_dec, o_alu_cin, o_alu_op_sel);
      end
      @(posedge i_clk); #1;
      checks++;
      if (o_alu_op_a !== 8'h2f || o_alu_op_b !== 8'hfa || o_rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL fix_drive: got a=%h b=%h valid=%b want 2f fa 0",
                  o_alu_op_a, o_alu_op_b, o_rsp_valid);
      end
      i_rst_n = 1'b0;
      #2;
      checks++;
      if ({o_rsp_valid, o_rsp_result, o_rsp_wr, o_rsp_flags, o_rsp_flag_we,
           o_rsp_err, o_alu_op_a, o_alu_op_b, o_alu_cin, o_alu_sub,
           o_alu_dec} !== 35'h0) begin
         errors++;
         $display("FAIL reset_in_fix: got valid=%b res=%h alu_a=%h alu_b=%h want 0",
                  o_rsp_valid, o_rsp_result, o_alu_op_a, o_alu_op_b);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge i_clk); #1;
         checks++;
         if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_reset_%0d: got valid=%b ready=%b want 0 1",
                     k, o_rsp_valid, o_req_ready);
         end
      end
   endtask

   initial begin
      repeat (3) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk); #1;
      test_reset();
      test_directed();
      test_random();
      test_back_to_back();
      test_illegal();
      test_hold_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
